// File: rtl/word_write_merger.sv
// Byte-lane write merger for the cache data array: read the addressed block,
// replace one word lane with the CPU write data, and write the block back.
module word_write_merger #(
  parameter int WORD_W   = 8,
  parameter int WORDS    = 4,
  parameter int OFFSET_W = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_req,
  input  logic [OFFSET_W-1:0]       wr_offset,
  input  logic [WORD_W-1:0]         wr_data,
  output logic                      busy,
  output logic                      line_rd_req,
  input  logic                      line_rd_valid,
  input  logic [WORD_W*WORDS-1:0]   line_rd_data,
  output logic                      line_wr_en,
  output logic [WORD_W*WORDS-1:0]   line_wr_data,
  output logic                      done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [OFFSET_W-1:0]       r_offset;
  logic [WORD_W-1:0]         r_data;
  logic [WORD_W*WORDS-1:0]   r_merged;
  logic [WORD_W*WORDS-1:0]   w_merged;
  logic                      r_busy;
  logic                      r_rd_req;
  logic                      r_wr_en;
  logic                      r_done;

  // Next-state decode; requests while busy and valid outside RD are ignored.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (wr_req) w_next = S_RD;
        else        w_next = S_IDLE;
      end
      S_RD: begin
        if (line_rd_valid) w_next = S_WR;
        else               w_next = S_RD;
      end
      S_WR:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Lane k occupies bits [k*WORD_W +: WORD_W]; untouched lanes pass through.
  always_comb begin
    w_merged = line_rd_data;
    for (int k = 0; k < WORDS; k++) begin
      if (r_offset == OFFSET_W'(k)) begin
        w_merged[k*WORD_W +: WORD_W] = r_data;
      end else begin
        w_merged[k*WORD_W +: WORD_W] = line_rd_data[k*WORD_W +: WORD_W];
      end
    end
  end

  // State, latches and outputs; outputs are registered from the next state so
  // they line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_offset <= '0;
      r_data   <= '0;
      r_merged <= '0;
      r_busy   <= 1'b0;
      r_rd_req <= 1'b0;
      r_wr_en  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_busy   <= (w_next != S_IDLE);
      r_rd_req <= (w_next == S_RD);
      r_wr_en  <= (w_next == S_WR);
      r_done   <= (w_next == S_DONE);
      if ((r_state == S_IDLE) && wr_req) begin
        r_offset <= wr_offset;
        r_data   <= wr_data;
      end else begin
        r_offset <= r_offset;
        r_data   <= r_data;
      end
      if ((r_state == S_RD) && line_rd_valid) begin
        r_merged <= w_merged;
      end else begin
        r_merged <= r_merged;
      end
    end
  end

  assign busy         = r_busy;
  assign line_rd_req  = r_rd_req;
  assign line_wr_en   = r_wr_en;
  assign line_wr_data = r_merged;
  assign done         = r_done;

endmodule

// File: tb/tb_word_write_merger.sv
// Scoreboard bench for word_write_merger: the driver pushes expected merged
// blocks, a negedge monitor pops them whenever line_wr_en is seen.
module tb_word_write_merger;

  logic        clk;
  logic        rst_n;
  logic        wr_req;
  logic [1:0]  wr_offset;
  logic [7:0]  wr_data;
  logic        busy;
  logic        line_rd_req;
  logic        line_rd_valid;
  logic [31:0] line_rd_data;
  logic        line_wr_en;
  logic [31:0] line_wr_data;
  logic        done;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb_q[$];
  logic        prev_wr_en = 1'b0;

  word_write_merger #(.WORD_W(8), .WORDS(4), .OFFSET_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_offset(wr_offset),
    .wr_data(wr_data), .busy(busy), .line_rd_req(line_rd_req),
    .line_rd_valid(line_rd_valid), .line_rd_data(line_rd_data),
    .line_wr_en(line_wr_en), .line_wr_data(line_wr_data), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: clear the byte lane with a mask, then OR in the shifted data.
  function automatic logic [31:0] ref_merge(input logic [31:0] blk, input int off,
                                            input logic [7:0] d);
    logic [31:0] mask;
    mask = 32'h0000_00FF << (8 * off);
    return (blk & ~mask) | ({24'h0, d} << (8 * off));
  endfunction

  // Monitor: every write strobe must match the oldest outstanding expectation,
  // and done must trail each strobe by exactly one cycle.
  always @(negedge clk) begin
    logic [31:0] exp;
    if (line_wr_en === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_wr_en", 32'd1, 32'd0);
      end else begin
        exp = sb_q.pop_front();
        chk("wr_data", line_wr_data, exp);
      end
    end
    if ((done === 1'b1) || prev_wr_en) begin
      chk("done_after_wr_en", {31'd0, done}, {31'd0, prev_wr_en});
    end
    prev_wr_en = (line_wr_en === 1'b1);
  end

  // One write transaction; called and returning at #1 after a posedge in IDLE.
  task automatic do_write(input logic [1:0] off, input logic [7:0] d,
                          input logic [31:0] rd, input int stall, input bit ghost,
                          input logic [31:0] exp);
    int rq_cycles;
    rq_cycles = 0;
    wr_req = 1'b1; wr_offset = off; wr_data = d;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    wr_req    = ghost;
    wr_offset = 2'd0;
    wr_data   = 8'h55;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (line_rd_req === 1'b1) rq_cycles++;
      chk("no_early_wr_en", {31'd0, line_wr_en}, 32'd0);
      chk("busy_in_rd", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    line_rd_valid = 1'b1;
    line_rd_data  = rd;
    @(negedge clk);
    if (line_rd_req === 1'b1) rq_cycles++;
    @(posedge clk); #1;
    line_rd_valid = 1'b0;
    line_rd_data  = $urandom;
    wr_req        = 1'b0;
    chk("rd_req_cycles", rq_cycles, stall + 1);
    @(negedge clk);
    chk("wr_en_latency", {31'd0, line_wr_en}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_latency", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_clear", {29'd0, busy, line_rd_req, line_wr_en}, 32'd0);
    chk("wr_data_hold", line_wr_data, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [1:0]  off;
    logic [7:0]  d;
    logic [31:0] rd;
    rst_n = 1'b0; wr_req = 1'b1; wr_offset = 2'd3; wr_data = 8'hFF;
    line_rd_valid = 1'b0; line_rd_data = 32'h0;

    // Reset held with a pending request: everything stays quiet.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("reset_ctrl", {28'd0, busy, line_rd_req, line_wr_en, done}, 32'd0);
      chk("reset_wr_data", line_wr_data, 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; wr_req = 1'b0;
    @(posedge clk); #1;

    do_write(2'd2, 8'hAB, 32'h11223344, 0, 1'b0, 32'h11AB3344);
    do_write(2'd0, 8'hF0, 32'h0, 0, 1'b0, 32'h000000F0);
    do_write(2'd1, 8'hF1, 32'h0, 0, 1'b0, 32'h0000F100);
    do_write(2'd2, 8'hF2, 32'h0, 0, 1'b0, 32'h00F20000);
    do_write(2'd3, 8'hF3, 32'h0, 0, 1'b0, 32'hF3000000);
    do_write(2'd1, 8'h9C, 32'hDEADBEEF, 5, 1'b0, 32'hDEAD9CEF);
    do_write(2'd3, 8'h3C, 32'hCAFEF00D, 0, 1'b0, 32'h3CFEF00D);
    do_write(2'd2, 8'h77, 32'h01234567, 2, 1'b1, 32'h01774567);

    for (int n = 0; n < 30; n++) begin
      // Idle noise: valid outside RD must be ignored.
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        line_rd_valid = 1'($urandom);
        line_rd_data  = $urandom;
        @(posedge clk); #1;
      end
      line_rd_valid = 1'b0;
      off = 2'($urandom);
      d   = 8'($urandom);
      rd  = $urandom;
      do_write(off, d, rd, int'($urandom_range(0, 4)), 1'($urandom),
               ref_merge(rd, int'(off), d));
    end

    // Abort: reset lands on the edge that would have moved RD to WR.
    wr_req = 1'b1; wr_offset = 2'd1; wr_data = 8'hEE;
    @(posedge clk); #1;
    wr_req = 1'b0;
    line_rd_valid = 1'b1; line_rd_data = 32'h12345678;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; line_rd_valid = 1'b0;
    @(negedge clk);
    chk("abort_ctrl", {28'd0, busy, line_rd_req, line_wr_en, done}, 32'd0);
    chk("abort_wr_data", line_wr_data, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_wr_en", {31'd0, line_wr_en}, 32'd0);
    end
    @(posedge clk); #1;
    do_write(2'd0, 8'h5A, 32'hA5A5A5A5, 1, 1'b0, 32'hA5A5A55A);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
